flick_conditioner: RTL and testbench
====================================

FLICK_CONDITIONER -- requirements
Module: flick_conditioner

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive synchronized cycles at a new level required to accept it (legal range 2..256).
REQ-002 The module SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port flick_raw  input  1  asynchronous, bouncing push-button level.
REQ-005 The module SHALL have port flick  output  1  debounced flick level; it drives the flick input of the system control block.
REQ-006 The module SHALL have port flick_rise  output  1  one-cycle pulse when flick goes 0->1.
REQ-007 The module SHALL have port flick_fall  output  1  one-cycle pulse when flick goes 1->0.

Function
REQ-008 The module SHALL pass flick_raw through a 2-flop synchronizer; only the second-flop value (sync) feeds the FSM.
REQ-009 The FSM SHALL have the states LOW, RISE_CHK, HIGH and FALL_CHK, plus a debounce counter of width clog2(DEBOUNCE_CYCLES).
REQ-010 LOW: if sync=1, the FSM SHALL go to RISE_CHK with the counter cleared to 0; otherwise it SHALL stay in LOW.
REQ-011 RISE_CHK: if sync=0, the FSM SHALL return to LOW with the counter cleared.
REQ-012 RISE_CHK: if sync=1 and counter=DEBOUNCE_CYCLES-1, the FSM SHALL go to HIGH; otherwise, with sync=1, the counter SHALL increment by 1.
REQ-013 HIGH and FALL_CHK SHALL mirror LOW and RISE_CHK with sync polarity inverted, ending in LOW.
REQ-014 flick SHALL be 1 exactly in states HIGH and FALL_CHK; it SHALL be registered, with no combinational path from flick_raw.
REQ-015 flick_rise SHALL be 1 for exactly the one cycle in which flick first reads 1 after a 0.
REQ-016 flick_fall SHALL be 1 for exactly the one cycle in which flick first reads 0 after a 1.
REQ-017 flick_rise and flick_fall SHALL never be 1 in the same cycle.
REQ-018 Latency: if flick_raw is first sampled 1 at edge k and held, flick SHALL read 1 after edge k+2+DEBOUNCE_CYCLES; the fall latency SHALL be symmetric.
REQ-019 Any sync excursion shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on flick, flick_rise or flick_fall.
REQ-020 The counter SHALL never wrap; its maximum value is DEBOUNCE_CYCLES-1.

Reset
REQ-021 While rst=1, both synchronizer flops SHALL be 0, the FSM SHALL be in LOW, the counter SHALL be 0, and flick, flick_rise and flick_fall SHALL be 0.
REQ-022 Reset asserted in any state, including mid-count, SHALL take effect at the next edge and discard the count; no flick_fall pulse SHALL be generated by reset.
REQ-023 If flick_raw=1 when rst deasserts, flick SHALL rise at DEBOUNCE_CYCLES+2 edges after the first edge with rst=0.

Structure
REQ-024 The state typedef flick_state_t and the constant FLICK_DEBOUNCE_DEFAULT=16 SHALL reside in the shared package bound_flasher_pkg.
REQ-025 The synchronizer SHALL be the sub-module sync_2ff (clk, rst, d, q), reusable elsewhere in the codebase.
REQ-026 The FSM, counter and pulse generation SHALL reside in flick_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 The bench SHALL apply: flick_raw 0->1 at edge 10, held 20 cycles -> flick=1 after edge 16, and flick_rise=1 only in cycle 16-17.
REQ-028 The bench SHALL apply: flick_raw high for 3 cycles, then low -> flick, flick_rise and flick_fall stay 0 throughout.
REQ-029 The bench SHALL apply: with flick=1, flick_raw bounces 1-0-1-0-1 (1 cycle each), then stays 0 -> exactly one flick_fall, 6 edges after the final 1->0.
REQ-030 The bench SHALL apply: rst=1 for one cycle while in RISE_CHK with counter=2 -> next cycle in state LOW with counter 0 and all outputs 0; no pulse.
REQ-031 The bench SHALL apply: rst released with flick_raw=1 -> flick rises after 6 edges, and a single flick_rise is seen.
REQ-032 The bench SHALL check, every cycle, that flick_rise and flick_fall are never both 1, and that each pulse coincides with a flick transition.

Source files
------------

// File: rtl/bound_flasher_pkg.sv
// Shared types and constants for the flick input conditioning path.
package bound_flasher_pkg;

  // Debounce FSM states: stable low, candidate rise, stable high, candidate fall.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } flick_state_t;

  // Default number of consecutive stable synchronized cycles to accept a new level.
  localparam int FLICK_DEBOUNCE_DEFAULT = 16;

endpackage : bound_flasher_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/flick_conditioner.sv
// Debounces the flick push-button: synchronize, require DEBOUNCE_CYCLES stable
// cycles at the new level, and emit one-cycle rise/fall pulses on each accepted edge.
module flick_conditioner
  import bound_flasher_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = FLICK_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic flick_raw,
  output logic flick,
  output logic flick_rise,
  output logic flick_fall
);

  // Width holds 0..DEBOUNCE_CYCLES-1 exactly; never below one bit.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync;
  flick_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flick_q, flick_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (flick_raw),
    .q   (sync)
  );

  // Next-state logic: a candidate level must persist for the full count, any
  // glitch back to the old level abandons the candidate and clears the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        if (sync) begin
          state_d = RISE_CHK;
          cnt_d   = '0;
        end
      end
      RISE_CHK: begin
        if (!sync) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!sync) begin
          state_d = FALL_CHK;
          cnt_d   = '0;
        end
      end
      FALL_CHK: begin
        if (sync) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
    flick_d = (state_d == HIGH) || (state_d == FALL_CHK);
  end

  // State, counter and outputs all registered; reset wins and never emits a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      flick_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flick_q <= flick_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign flick      = flick_q;
  assign flick_rise = rise_q;
  assign flick_fall = fall_q;

endmodule : flick_conditioner

// File: tb/tb_flick_conditioner.sv
// Directed bench for flick_conditioner with DEBOUNCE_CYCLES=4.
module tb_flick_conditioner;
  import bound_flasher_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flick_raw = 1'b0;
  logic flick, flick_rise, flick_fall;

  int checks = 0;
  int failures = 0;

  flick_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flick_raw  (flick_raw),
    .flick      (flick),
    .flick_rise (flick_rise),
    .flick_fall (flick_fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_v;
    logic raw_v;
    logic exp_flick;
    logic exp_rise;
    logic exp_fall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic w, input logic f, input logic ri, input logic fa);
    vec_t v;
    v.rst_v = r; v.raw_v = w; v.exp_flick = f; v.exp_rise = ri; v.exp_fall = fa;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants: never both pulses, and each pulse matches a flick transition.
  logic mon_en = 1'b0;
  logic prev_flick = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("both_pulses", 0, {31'd0, flick_rise & flick_fall}, 32'd0);
      if (flick_rise) chk("rise_no_edge", 0, {30'd0, prev_flick, flick}, 32'b01);
      if (flick_fall) chk("fall_no_edge", 0, {30'd0, prev_flick, flick}, 32'b10);
    end
    prev_flick = flick;
  end

  initial begin
    // Edge e is the edge at which vector e is sampled.
    add(1, 0, 0, 0, 0);                                   // e0
    add(1, 0, 0, 0, 0);                                   // e1
    for (int e = 2; e <= 9; e++) add(0, 0, 0, 0, 0);
    // Raw rises at e10 held 20 cycles: flick from e16, rise only at e16.
    for (int e = 10; e <= 29; e++) add(0, 1, (e >= 16), (e == 16), 0);
    // Raw low from e30: flick drops at e36 with a single fall.
    for (int e = 30; e <= 40; e++) add(0, 0, (e < 36), 0, (e == 36));
    // Three-cycle glitch e41..e43: no effect.
    for (int e = 41; e <= 52; e++) add(0, (e <= 43), 0, 0, 0);
    // Raw high from e53: flick at e59.
    for (int e = 53; e <= 62; e++) add(0, 1, (e >= 59), (e == 59), 0);
    // Bounce 0,1,0,1 at e63..e66, then low from e67: single fall at e73.
    for (int e = 63; e <= 76; e++)
      add(0, (e == 64 || e == 66), (e < 73), 0, (e == 73));
    // Reset with raw=1, released at e78: flick at e84 with single rise.
    add(1, 1, 0, 0, 0);                                   // e77
    for (int e = 78; e <= 88; e++) add(0, 1, (e >= 84), (e == 84), 0);
    // Reset while HIGH: flick clears, no fall pulse.
    add(1, 1, 0, 0, 0);                                   // e89
    add(1, 0, 0, 0, 0);                                   // e90

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst_v;
      flick_raw = vecs[i].raw_v;
      step();
      chk("flick", i, {31'd0, flick}, {31'd0, vecs[i].exp_flick});
      chk("flick_rise", i, {31'd0, flick_rise}, {31'd0, vecs[i].exp_rise});
      chk("flick_fall", i, {31'd0, flick_fall}, {31'd0, vecs[i].exp_fall});
      if (i == 1) begin
        chk("rst_state", i, {30'd0, dut.state_q}, {30'd0, LOW});
        chk("rst_sync", i, {31'd0, dut.sync}, 32'd0);
      end
      if (i == 0) mon_en = 1'b1;
    end

    // Reset mid-count: reach RISE_CHK with counter 2, then one reset cycle.
    rst = 1'b0;
    flick_raw = 1'b0;
    repeat (3) step();
    flick_raw = 1'b1;
    repeat (5) step();
    chk("midcount_state", 0, {30'd0, dut.state_q}, {30'd0, RISE_CHK});
    chk("midcount_cnt", 0, 32'(dut.cnt_q), 32'd2);
    rst = 1'b1;
    step();
    chk("post_rst_state", 0, {30'd0, dut.state_q}, {30'd0, LOW});
    chk("post_rst_cnt", 0, 32'(dut.cnt_q), 32'd0);
    chk("post_rst_sync", 0, {31'd0, dut.sync}, 32'd0);
    chk("post_rst_outs", 0, {29'd0, flick, flick_rise, flick_fall}, 32'd0);
    rst = 1'b0;
    flick_raw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_quiet", k, {29'd0, flick, flick_rise, flick_fall}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_flick_conditioner
